step_sequencer: RTL and testbench
=================================

// Module: step_sequencer
// PURPOSE
// - Debug-side driver for clk_stepper: turns host/button commands into its active/step controls.
// - Supports free-run, halt, and bursts of N single-clock steps with programmable pulse shaping.
// - Sits between the debug command source (UART/buttons) and clk_stepper; reports progress back.
// PARAMETERS
// - COUNT_W    16  width of step count and steps_done
// - STEP_HIGH  1   cycles step is held high per step (>=1)
// - STEP_LOW   1   cycles step is held low between steps (>=1)
// PORTS
// - clk_in      in   1        system clock; rising edge only
// - rst_in      in   1        synchronous, active-high reset
// - cmd_valid   in   1        command present
// - cmd_ready   out  1        command accepted when cmd_valid & cmd_ready at a clk_in edge
// - cmd_op      in   2        0 NOP, 1 RUN, 2 HALT, 3 STEP
// - cmd_count   in   COUNT_W  number of steps for STEP
// - abort_in    in   1        terminate STEP burst, go HALT
// - active      out  1        to clk_stepper.active; 1 = gated/stepping mode
// - step        out  1        to clk_stepper.step
// - busy        out  1        STEP burst in progress
// - done        out  1        one-cycle pulse when a burst ends (complete or aborted)
// - steps_done  out  COUNT_W  steps issued in current/last burst
// - brk_in      in   1        breakpoint hit (only with STEP_SEQ_BREAK_EN)
// BEHAVIOUR
// - All outputs registered. Reset: state FREE, active=0, step=0, busy=0, done=0, steps_done=0.
// - States: FREE (active=0), HALTED (active=1, step=0), SETTLE, PULSE_HI, PULSE_LO.
// - cmd_ready = (state==FREE | state==HALTED) & !abort_in; combinational from state/abort.
// - NOP: accepted, no effect. RUN: -> FREE, active=0 next cycle. HALT: -> HALTED, active=1 next cycle.
// - STEP accepted at edge T: active=1, busy=1, steps_done=0 from T+1 (SETTLE, 1 cycle);
//   step=1 for STEP_HIGH cycles from T+2, then step=0 for STEP_LOW cycles; repeat cmd_count times.
// - steps_done increments on entry to each PULSE_LO (step falling). No wrap: max 2^COUNT_W-1.
// - After final PULSE_LO: -> HALTED, busy=0, done=1 for one cycle. Mode after burst is always HALTED.
// - cmd_count=0: SETTLE one cycle, no pulses, then HALTED with done pulse, steps_done=0.
// - abort_in in SETTLE/PULSE_HI/PULSE_LO: next cycle step=0, -> HALTED, busy=0, done=1;
//   an in-flight high phase is cut short and not counted. abort_in in FREE/HALTED: no effect.
// - abort_in with cmd_valid same cycle: abort wins, command not accepted (cmd_ready=0).
// - rst_in mid-burst: immediate return to reset values at next edge; no done pulse.
// - step never high while active=0; active never drops during a burst.
// CONFIGURATION
// - STEP_SEQ_BREAK_EN defined: brk_in sampled each cycle in PULSE_LO; if 1, burst ends as abort
//   after current step is counted (steps_done includes it), done=1. brk_in in FREE forces HALTED.
// - Not defined: brk_in port absent; bursts end only on count or abort_in.
// STRUCTURE
// - Shared package nese_dbg_pkg: step_op_t enum (OP_NOP/OP_RUN/OP_HALT/OP_STEP), step_state_t enum.
// - One sub-module: step_pulse_timer (loads STEP_HIGH/STEP_LOW, emits phase_end); FSM + counters here.
// TESTING
// - Reset: rst_in=1 two cycles -> active=0, step=0, busy=0, cmd_ready=1, steps_done=0.
// - HALT then RUN: cmd_op=2 -> active=1 next cycle; cmd_op=1 -> active=0 next cycle; no step pulses.
// - STEP count=3, HIGH=1, LOW=1 at edge T: step high at T+2,T+4,T+6; done at T+8; steps_done=3; active=1.
// - STEP count=0 -> no step pulse, done one cycle after SETTLE, steps_done=0, cmd_ready back to 1.
// - STEP count=10, abort_in during 4th high phase -> step=0 next cycle, steps_done=3, done=1, HALTED.
// - STEP_SEQ_BREAK_EN: STEP count=10, brk_in=1 during 2nd low phase -> steps_done=2, done=1, HALTED.

Source files
------------

// File: rtl/nese_dbg_pkg.sv
// Shared debug-path types: host command opcodes and step_sequencer FSM states.
package nese_dbg_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_RUN  = 2'd1,
    OP_HALT = 2'd2,
    OP_STEP = 2'd3
  } step_op_t;

  typedef enum logic [2:0] {
    ST_FREE     = 3'd0,
    ST_HALTED   = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_PULSE_HI = 3'd3,
    ST_PULSE_LO = 3'd4
  } step_state_t;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_pulse_timer.sv
// Phase length down-counter: load with (length-1) on phase entry, phase_end_o on its last cycle.
module step_pulse_timer #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         phase_end_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign phase_end_o = (cnt_q == '0);

endmodule

// File: rtl/step_sequencer.sv
// Debug command front-end for clk_stepper: free-run / halt / shaped step bursts.
// Optional breakpoint stop on STEP_SEQ_BREAK_EN (adds brk_in port).
module step_sequencer
  import nese_dbg_pkg::*;
#(
  parameter int COUNT_W   = 16,
  parameter int STEP_HIGH = 1,
  parameter int STEP_LOW  = 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic               abort_in,
  output logic               active,
  output logic               step,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] steps_done
`ifdef STEP_SEQ_BREAK_EN
  ,
  input  logic               brk_in
`endif
);

  localparam int TMR_W = $clog2(max_i(STEP_HIGH, STEP_LOW) + 1);

  step_state_t        state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] steps_q, steps_d;
  logic               active_q, step_q, busy_q, done_q, done_d;
  logic               tmr_load, phase_end, accept, brk;
  logic [TMR_W-1:0]   tmr_val;
  step_op_t           op;

`ifdef STEP_SEQ_BREAK_EN
  assign brk = brk_in;
`else
  assign brk = 1'b0;
`endif

  assign cmd_ready = ((state_q == ST_FREE) || (state_q == ST_HALTED)) && !abort_in;
  assign accept    = cmd_valid && cmd_ready;
  assign op        = step_op_t'(cmd_op);

  step_pulse_timer #(.W(TMR_W)) u_tmr (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .phase_end_o(phase_end)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    steps_d  = steps_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_FREE, ST_HALTED: begin
        if (accept) begin
          unique case (op)
            OP_RUN:  state_d = ST_FREE;
            OP_HALT: state_d = ST_HALTED;
            OP_STEP: begin
              state_d = ST_SETTLE;
              count_d = cmd_count;
              steps_d = '0;
            end
            default: ;
          endcase
        end
        // A breakpoint while free-running freezes the target unless a burst was just started.
        if (brk && state_q == ST_FREE && state_d == ST_FREE)
          state_d = ST_HALTED;
      end
      ST_SETTLE: begin
        if (abort_in || count_q == '0) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end else begin
          state_d  = ST_PULSE_HI;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(STEP_HIGH - 1);
        end
      end
      ST_PULSE_HI: begin
        if (abort_in) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end else if (phase_end) begin
          state_d  = ST_PULSE_LO;
          steps_d  = steps_q + 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(STEP_LOW - 1);
        end
      end
      ST_PULSE_LO: begin
        if (abort_in || brk || (phase_end && steps_q == count_q)) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end else if (phase_end) begin
          state_d  = ST_PULSE_HI;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(STEP_HIGH - 1);
        end
      end
      default: state_d = ST_FREE;
    endcase
  end

  // Outputs are registered copies decoded from the next state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_FREE;
      count_q  <= '0;
      steps_q  <= '0;
      active_q <= 1'b0;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      steps_q  <= steps_d;
      active_q <= (state_d != ST_FREE);
      step_q   <= (state_d == ST_PULSE_HI);
      busy_q   <= (state_d == ST_SETTLE) || (state_d == ST_PULSE_HI) || (state_d == ST_PULSE_LO);
      done_q   <= done_d;
    end
  end

  assign active     = active_q;
  assign step       = step_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_done = steps_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Randomized + directed bench for step_sequencer against a cycle-count based reference model.
module tb_step_sequencer;

  localparam int CW = 16;
  localparam int H  = 2;
  localparam int L  = 3;
  localparam int P  = H + L;
`ifdef STEP_SEQ_BREAK_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, cmd_valid, abort, brk;
  logic [1:0]    op;
  logic [CW-1:0] cnt;
  logic          cmd_ready, active, step, busy, done;
  logic [CW-1:0] steps_done;

  step_sequencer #(.COUNT_W(CW), .STEP_HIGH(H), .STEP_LOW(L)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (op),
    .cmd_count (cnt),
    .abort_in  (abort),
    .active    (active),
    .step      (step),
    .busy      (busy),
    .done      (done),
    .steps_done(steps_done)
`ifdef STEP_SEQ_BREAK_EN
    ,
    .brk_in    (brk)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: k = cycles since the STEP was accepted (1 = settle, then H high + L low per step).
  bit m_act, m_burst, m_done;
  int m_k, m_n, m_sd;

  function automatic int sd_of(input int k);
    int j;
    if (k < 2) return 0;
    j = k - 2;
    return (j / P) + (((j % P) >= H) ? 1 : 0);
  endfunction

  function automatic bit step_of(input bit burst, input int k);
    return burst && (k >= 2) && (((k - 2) % P) < H);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input bit r, input bit v, input logic [1:0] o, input int c,
                      input bit a, input bit b);
    bit was_free;
    rst = r; cmd_valid = v; op = o; cnt = c[CW-1:0]; abort = a; brk = b;
    #1;
    if (!r) chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, (!m_burst && !a)});
    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (r) begin
      m_act = 1'b0; m_burst = 1'b0; m_sd = 0; m_k = 0;
    end else if (m_burst) begin
      if (a || (BRK_EN && b && m_k >= 2 && ((m_k - 2) % P) >= H)) begin
        m_burst = 1'b0; m_done = 1'b1; m_sd = sd_of(m_k);
      end else begin
        m_k++;
        if (m_k == 2 + m_n * P) begin
          m_burst = 1'b0; m_done = 1'b1; m_sd = m_n;
        end else m_sd = sd_of(m_k);
      end
    end else begin
      was_free = !m_act;
      if (v && !a) begin
        case (o)
          2'd1: m_act = 1'b0;
          2'd2: m_act = 1'b1;
          2'd3: begin m_burst = 1'b1; m_k = 1; m_n = c; m_act = 1'b1; m_sd = 0; end
          default: ;
        endcase
      end
      if (BRK_EN && b && was_free && !m_burst) m_act = 1'b1;
    end
    chk("active",     {31'b0, active}, {31'b0, m_act});
    chk("step",       {31'b0, step},   {31'b0, step_of(m_burst, m_k)});
    chk("busy",       {31'b0, busy},   {31'b0, m_burst});
    chk("done",       {31'b0, done},   {31'b0, m_done});
    chk("steps_done", {16'b0, steps_done}, m_sd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 2'd0, 0, 0, 0);
  endtask

  // Idle until the model reaches burst cycle k; a miss counts as a failure.
  task automatic wait_k(input int k);
    int guard;
    guard = 0;
    while (m_burst && m_k != k && guard < 500) begin
      tick(0, 0, 2'd0, 0, 0, 0);
      guard++;
    end
    chk("wait_k_reached", {31'b0, (m_burst && m_k == k)}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; op = 2'd0; cnt = '0; abort = 1'b0; brk = 1'b0;
    m_act = 0; m_burst = 0; m_done = 0; m_k = 0; m_n = 0; m_sd = 0;

    tick(1, 0, 2'd0, 0, 0, 0);
    tick(1, 0, 2'd0, 0, 0, 0);
    idle(1);

    tick(0, 1, 2'd2, 0, 0, 0);           // HALT
    idle(2);
    tick(0, 1, 2'd1, 0, 0, 0);           // RUN
    idle(2);
    tick(0, 1, 2'd0, 0, 0, 0);           // NOP

    tick(0, 1, 2'd3, 3, 0, 0);           // STEP 3
    idle(2 + 3 * P);
    tick(0, 1, 2'd3, 0, 0, 0);           // STEP 0
    idle(3);

    tick(0, 1, 2'd3, 10, 0, 0);          // abort in 4th high phase
    wait_k(2 + 3 * P);
    tick(0, 0, 2'd0, 0, 1, 0);
    idle(2);

    tick(0, 1, 2'd1, 0, 1, 0);           // abort beats a RUN in HALTED
    idle(1);

    tick(0, 1, 2'd3, 5, 0, 0);           // abort during a low phase counts that step
    wait_k(2 + P + H + 1);
    tick(0, 0, 2'd0, 0, 1, 0);
    idle(1);

    tick(0, 1, 2'd3, 6, 0, 0);           // reset mid-burst
    idle(4);
    tick(1, 0, 2'd0, 0, 0, 0);
    idle(2);

`ifdef STEP_SEQ_BREAK_EN
    tick(0, 1, 2'd3, 10, 0, 0);          // breakpoint in 2nd low phase
    wait_k(2 + P + H);
    tick(0, 0, 2'd0, 0, 0, 1);
    idle(2);
    tick(0, 1, 2'd1, 0, 0, 0);
    tick(0, 0, 2'd0, 0, 0, 1);           // breakpoint while free-running
    idle(1);
`endif

    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 150) == 0, $urandom % 2, 2'($urandom % 4), $urandom % 6,
           ($urandom % 25) == 0, ($urandom % 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
